// File: rtl/ga_sched_pkg.sv
// Shared types and constants for the GA fitness scheduler slice.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a. CHROM_WIDTH / FITNESS_WIDTH normally come from
// common_defines.vh; defaults are provided here when that header is absent.
`ifndef CHROM_WIDTH
`define CHROM_WIDTH 16
`endif
`ifndef FITNESS_WIDTH
`define FITNESS_WIDTH 16
`endif

package ga_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  // Index width for a population; a population of 1 still needs one bit.
  function automatic int idx_w(input int pop);
    return (pop <= 1) ? 1 : $clog2(pop);
  endfunction

  // Most-negative fitness: the running maximum starts here so any real
  // value can replace it.
  localparam logic signed [`FITNESS_WIDTH-1:0] FIT_MIN =
    {1'b1, {(`FITNESS_WIDTH-1){1'b0}}};

endpackage

// File: rtl/fit_best_tracker.sv
// Pair compare plus running maximum of fitness over one generation.
// Latency: best_* reflect an update one cycle after update_i.
// Backpressure: none; accepts one pair per cycle.
// Ports: clear_i resets best to FIT_MIN/0, update_i folds in a pair
// (idx1_i/fit1_i lane 1, idx2_i/fit2_i lane 2); best_idx_o/best_fit_o.
module fit_best_tracker
  import ga_sched_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear_i,
  input  logic                             update_i,
  input  logic [IDX_W-1:0]                 idx1_i,
  input  logic [IDX_W-1:0]                 idx2_i,
  input  logic signed [`FITNESS_WIDTH-1:0] fit1_i,
  input  logic signed [`FITNESS_WIDTH-1:0] fit2_i,
  output logic [IDX_W-1:0]                 best_idx_o,
  output logic signed [`FITNESS_WIDTH-1:0] best_fit_o
);

  logic [IDX_W-1:0]                 best_idx_q, best_idx_d;
  logic signed [`FITNESS_WIDTH-1:0] best_fit_q, best_fit_d;
  logic [IDX_W-1:0]                 win_idx;
  logic signed [`FITNESS_WIDTH-1:0] win_fit;

  always_comb begin
    // Lane 1 holds the even (lower) index, so it wins a tie within the pair.
    if (fit1_i >= fit2_i) begin
      win_idx = idx1_i;
      win_fit = fit1_i;
    end else begin
      win_idx = idx2_i;
      win_fit = fit2_i;
    end

    best_idx_d = best_idx_q;
    best_fit_d = best_fit_q;
    if (clear_i) begin
      best_idx_d = '0;
      best_fit_d = FIT_MIN;
    end else if (update_i && (win_fit > best_fit_q)) begin
      // Strictly greater: pairs arrive in ascending index order, so an
      // equal later value never displaces the earlier (lower) index.
      best_idx_d = win_idx;
      best_fit_d = win_fit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_idx_q <= '0;
      best_fit_q <= FIT_MIN;
    end else begin
      best_idx_q <= best_idx_d;
      best_fit_q <= best_fit_d;
    end
  end

  assign best_idx_o = best_idx_q;
  assign best_fit_o = best_fit_q;

endmodule

// File: rtl/fitness_scheduler.sv
// Sequences one generation through the dual-lane fitness evaluator: reads
// chromosome pairs, streams them one pair per cycle, writes results back.
// Latency: done pulses 1 + POP_SIZE/2 + 1 + FF_LATENCY + 1 cycles after start.
// Backpressure: none; memories and evaluator must accept one pair per cycle.
// Ports: start/abort control, busy/done status, pop_raddr*/pop_rdata* read
// side, ff_* evaluator side, fit_* write side, best_idx/best_fit result.
// Optional: define FIT_SCHED_STATS_EN to add the fit_sum output.
// FF_LATENCY must be at least 1.
module fitness_scheduler
  import ga_sched_pkg::*;
#(
  parameter int POP_SIZE   = 16,
  parameter int FF_LATENCY = 3,
  parameter int IDX_W      = idx_w(POP_SIZE)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic                                   abort,
  output logic                                   busy,
  output logic                                   done,
  output logic [IDX_W-1:0]                       pop_raddr1,
  output logic [IDX_W-1:0]                       pop_raddr2,
  input  logic [`CHROM_WIDTH-1:0]                pop_rdata1,
  input  logic [`CHROM_WIDTH-1:0]                pop_rdata2,
  output logic signed [`CHROM_WIDTH-1:0]         ff_chrom1,
  output logic signed [`CHROM_WIDTH-1:0]         ff_chrom2,
  output logic                                   ff_enable,
  input  logic signed [`FITNESS_WIDTH-1:0]       ff_fitness1,
  input  logic signed [`FITNESS_WIDTH-1:0]       ff_fitness2,
  output logic                                   fit_we,
  output logic [IDX_W-1:0]                       fit_waddr1,
  output logic [IDX_W-1:0]                       fit_waddr2,
  output logic [`FITNESS_WIDTH-1:0]              fit_wdata1,
  output logic [`FITNESS_WIDTH-1:0]              fit_wdata2,
`ifdef FIT_SCHED_STATS_EN
  output logic signed [`FITNESS_WIDTH+IDX_W-1:0] fit_sum,
`endif
  output logic [IDX_W-1:0]                       best_idx,
  output logic signed [`FITNESS_WIDTH-1:0]       best_fit
);

  localparam logic [IDX_W-1:0] LAST_P = IDX_W'(POP_SIZE / 2 - 1);

  sched_state_t       state_q, state_d;
  logic [IDX_W-1:0]   p_q, p_d;
  logic [FF_LATENCY:0] vld_q, vld_d;
  // Pair index travelling alongside each valid bit.
  logic [IDX_W-1:0]   pidx_q [FF_LATENCY+1];
  logic               issue;
  logic               start_acc;
  logic [IDX_W-1:0]   wr_pair;

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    issue     = 1'b0;
    start_acc = 1'b0;

    unique case (state_q)
      IDLE: begin
        // abort outranks a coincident start.
        if (start && !abort) begin
          state_d   = ISSUE;
          p_d       = '0;
          start_acc = 1'b1;
        end
      end
      ISSUE: begin
        issue = 1'b1;
        p_d   = p_q + 1'b1;
        if (p_q == LAST_P) state_d = DRAIN;
      end
      DRAIN: begin
        if (vld_q == '0) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (abort && (state_q != IDLE)) state_d = IDLE;
  end

  // Valid pipeline: stage 0 is the read-data cycle, stage FF_LATENCY is the
  // cycle the evaluator result is present. abort empties it in one step.
  always_comb begin
    vld_d = '0;
    if (!abort) begin
      vld_d[0] = issue;
      for (int i = 1; i <= FF_LATENCY; i++) vld_d[i] = vld_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p_q     <= '0;
      vld_q   <= '0;
      for (int i = 0; i <= FF_LATENCY; i++) pidx_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      vld_q     <= vld_d;
      pidx_q[0] <= p_q;
      for (int i = 1; i <= FF_LATENCY; i++) pidx_q[i] <= pidx_q[i-1];
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign busy = (state_q == ISSUE) || (state_q == DRAIN);
  assign done = (state_q == DONE);

  assign pop_raddr1 = issue ? (p_q << 1)                 : '0;
  assign pop_raddr2 = issue ? ((p_q << 1) | IDX_W'(1))   : '0;

  // Memory read data feeds the evaluator directly.
  assign ff_chrom1 = pop_rdata1;
  assign ff_chrom2 = pop_rdata2;

  // Covers every data/result cycle in flight, and all of DRAIN.
  assign ff_enable = (|vld_q) || (state_q == DRAIN);

  // Gating with abort keeps the abort cycle itself from writing.
  assign wr_pair    = pidx_q[FF_LATENCY];
  assign fit_we     = vld_q[FF_LATENCY] && !abort;
  assign fit_waddr1 = wr_pair << 1;
  assign fit_waddr2 = (wr_pair << 1) | IDX_W'(1);
  assign fit_wdata1 = ff_fitness1;
  assign fit_wdata2 = ff_fitness2;

  fit_best_tracker #(
    .IDX_W (IDX_W)
  ) u_best (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (start_acc),
    .update_i   (fit_we),
    .idx1_i     (fit_waddr1),
    .idx2_i     (fit_waddr2),
    .fit1_i     (ff_fitness1),
    .fit2_i     (ff_fitness2),
    .best_idx_o (best_idx),
    .best_fit_o (best_fit)
  );

`ifdef FIT_SCHED_STATS_EN
  localparam int SUM_W = `FITNESS_WIDTH + IDX_W;

  logic signed [SUM_W-1:0] fit_sum_q, fit_sum_d;
  logic signed [SUM_W-1:0] ext1, ext2;

  // IDX_W guard bits make overflow impossible for a full generation.
  assign ext1 = {{IDX_W{ff_fitness1[`FITNESS_WIDTH-1]}}, ff_fitness1};
  assign ext2 = {{IDX_W{ff_fitness2[`FITNESS_WIDTH-1]}}, ff_fitness2};

  always_comb begin
    fit_sum_d = fit_sum_q;
    if (start_acc)   fit_sum_d = '0;
    else if (fit_we) fit_sum_d = fit_sum_q + ext1 + ext2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fit_sum_q <= '0;
    else        fit_sum_q <= fit_sum_d;
  end

  assign fit_sum = fit_sum_q;
`endif

endmodule

// File: tb/tb_fitness_scheduler.sv
// Directed bench for fitness_scheduler with POP_SIZE=16, FF_LATENCY=3.
// Models a 1-cycle-latency population memory (chrom i = i) and a 3-cycle
// evaluator returning fit_tab[chrom]; expectations are hand-derived.
module tb_fitness_scheduler;

  localparam int CW    = `CHROM_WIDTH;
  localparam int FW    = `FITNESS_WIDTH;
  localparam int IDX_W = 4;
  localparam int FMIN  = -(1 << (FW - 1));

  logic clk, rst_n, start, abort;
  logic busy, done, ff_enable, fit_we;
  logic [IDX_W-1:0] pop_raddr1, pop_raddr2, fit_waddr1, fit_waddr2, best_idx;
  logic [CW-1:0] pop_rdata1, pop_rdata2;
  logic signed [CW-1:0] ff_chrom1, ff_chrom2;
  logic signed [FW-1:0] ff_fitness1, ff_fitness2, fit_wdata1, fit_wdata2, best_fit;
`ifdef FIT_SCHED_STATS_EN
  logic signed [FW+IDX_W-1:0] fit_sum;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [CW-1:0]        mem     [16];
  logic signed [FW-1:0] fit_tab [16];
  logic signed [FW-1:0] e1 [3];
  logic signed [FW-1:0] e2 [3];

  fitness_scheduler #(.POP_SIZE(16), .FF_LATENCY(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .pop_raddr1  (pop_raddr1),
    .pop_raddr2  (pop_raddr2),
    .pop_rdata1  (pop_rdata1),
    .pop_rdata2  (pop_rdata2),
    .ff_chrom1   (ff_chrom1),
    .ff_chrom2   (ff_chrom2),
    .ff_enable   (ff_enable),
    .ff_fitness1 (ff_fitness1),
    .ff_fitness2 (ff_fitness2),
    .fit_we      (fit_we),
    .fit_waddr1  (fit_waddr1),
    .fit_waddr2  (fit_waddr2),
    .fit_wdata1  (fit_wdata1),
    .fit_wdata2  (fit_wdata2),
`ifdef FIT_SCHED_STATS_EN
    .fit_sum     (fit_sum),
`endif
    .best_idx    (best_idx),
    .best_fit    (best_fit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Population memory: 1-cycle read latency.
  always @(posedge clk) begin
    pop_rdata1 <= mem[pop_raddr1];
    pop_rdata2 <= mem[pop_raddr2];
  end

  // Evaluator: fitness = fit_tab[chrom], 3 cycles after chrom is presented.
  always @(posedge clk) begin
    e1[0] <= fit_tab[ff_chrom1[3:0]];
    e2[0] <= fit_tab[ff_chrom2[3:0]];
    e1[1] <= e1[0];
    e2[1] <= e2[0];
    e1[2] <= e1[1];
    e2[2] <= e2[1];
  end
  assign ff_fitness1 = e1[2];
  assign ff_fitness2 = e2[2];

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full generation. Interval k = k cycles after the edge that sampled start.
  // Issues at k=0..7, writes at k=4..11, done at k=13.
  task automatic run_gen(input string nm, input int exp_idx, input int exp_fit,
                         input int exp_sum, input bit restart_mid);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      start = (restart_mid && k == 3);
`ifdef FIT_SCHED_STATS_EN
      if (k == 0) chk($sformatf("%s sum_clear", nm), fit_sum, 0);
`endif
      chk($sformatf("%s we k%0d", nm, k), fit_we, (k >= 4 && k <= 11));
      if (k >= 4 && k <= 11) begin
        chk($sformatf("%s waddr1 k%0d", nm, k), fit_waddr1, 2 * (k - 4));
        chk($sformatf("%s waddr2 k%0d", nm, k), fit_waddr2, 2 * (k - 4) + 1);
        chk($sformatf("%s wdata1 k%0d", nm, k), fit_wdata1, fit_tab[2 * (k - 4)]);
        chk($sformatf("%s wdata2 k%0d", nm, k), fit_wdata2, fit_tab[2 * (k - 4) + 1]);
      end
      if (k <= 7) chk($sformatf("%s raddr1 k%0d", nm, k), pop_raddr1, 2 * k);
      if (k <= 7) chk($sformatf("%s raddr2 k%0d", nm, k), pop_raddr2, 2 * k + 1);
      chk($sformatf("%s done k%0d", nm, k), done, (k == 13));
      chk($sformatf("%s ffen k%0d", nm, k), ff_enable, (k >= 1 && k <= 12));
      if (k <= 12) chk($sformatf("%s busy k%0d", nm, k), busy, 1);
      tick();
    end
    start = 1'b0;
    chk($sformatf("%s busy_end", nm), busy, 0);
    chk($sformatf("%s best_idx", nm), best_idx, exp_idx);
    chk($sformatf("%s best_fit", nm), best_fit, exp_fit);
`ifdef FIT_SCHED_STATS_EN
    chk($sformatf("%s fit_sum", nm), fit_sum, exp_sum);
`else
    if (exp_sum == 0) tick();
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = CW'(i);
    for (int i = 0; i < 16; i++) fit_tab[i] = FW'(10 * i);

    // Reset state.
    #12;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst fit_we", fit_we, 0);
    chk("rst ff_enable", ff_enable, 0);
    chk("rst raddr1", pop_raddr1, 0);
    chk("rst waddr1", fit_waddr1, 0);
    chk("rst best_idx", best_idx, 0);
    chk("rst best_fit", best_fit, FMIN);
    rst_n = 1'b1;
    tick();

    // Ramp fitness 10*i: best is the last individual.
    run_gen("ramp", 15, 150, 1200, 1'b0);

    // Two maxima of 500 at 4 and 9: lower index kept.
    for (int i = 0; i < 16; i++) fit_tab[i] = FW'(20 * i);
    fit_tab[4] = 500;
    fit_tab[9] = 500;
    run_gen("tie", 4, 500, 3140, 1'b0);

    // All negative: FIT_MIN never wins.
    for (int i = 0; i < 16; i++) fit_tab[i] = FW'(-1000 + i);
    run_gen("neg", 15, -985, -15880, 1'b0);

    // abort with start in IDLE: nothing starts.
    for (int i = 0; i < 16; i++) fit_tab[i] = FW'(10 * i);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("abst busy", busy, 0);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("abst we k%0d", k), fit_we, 0);
      tick();
    end

    // abort on the third ISSUE cycle.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("abort busy0", busy, 1);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort ffen", ff_enable, 0);
    for (int k = 0; k < 14; k++) begin
      chk($sformatf("abort we k%0d", k), fit_we, 0);
      chk($sformatf("abort done k%0d", k), done, 0);
      tick();
    end
    chk("abort best_fit", best_fit, FMIN);
    chk("abort best_idx", best_idx, 0);

    // Clean run after abort, with a start pulse while busy.
    run_gen("restart", 15, 150, 1200, 1'b1);

    // Reset asserted mid-DRAIN (interval 9, a write cycle).
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    chk("pre_rst we", fit_we, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst we", fit_we, 0);
    chk("mid_rst busy", busy, 0);
    chk("mid_rst ffen", ff_enable, 0);
    chk("mid_rst waddr1", fit_waddr1, 0);
    chk("mid_rst best_idx", best_idx, 0);
    chk("mid_rst best_fit", best_fit, FMIN);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("post_rst we k%0d", k), fit_we, 0);
      chk($sformatf("post_rst done k%0d", k), done, 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
